regfile_fwd: RTL and testbench
==============================

# regfile_fwd

Parametrised register-file read stage for the 16-bit datapath and successor to the fixed 16x16 RegFile. It decodes the instruction into an opcode and two source addresses and returns registered operands. Write data from the write-back stage is forwarded into a same-cycle read. A per-register busy scoreboard flags read-after-write hazards against outstanding producers, so the control unit can stall issue.

## Interface
Parameters:
- DATA_W, 16, register and operand width
- ADDR_W, 4, register address width; depth = 2^ADDR_W
- OPC_W, 4, opcode width; instruction width INSTR_W = OPC_W + 3*ADDR_W (16 at defaults)
- ZERO_REG, 1, when 1, register 0 reads as 0, ignores writes and is never marked busy

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- instruc_in  in  INSTR_W  instruction; fields [INSTR_W-1 -: OPC_W] opcode, next ADDR_W rs1, next ADDR_W rs2, low ADDR_W rd
- Reserve  in  1  issue of instruc_in will write rd; request to mark rd busy
- Writedata  in  DATA_W  write-back data
- WriteReg  in  ADDR_W  write-back destination address
- RegWrite  in  1  write enable for Writedata into WriteReg
- op1  out  DATA_W  registered operand for rs1
- op2  out  DATA_W  registered operand for rs2
- opcode  out  OPC_W  registered opcode field
- stall  out  1  registered hazard flag for the instruction now on op1/op2/opcode
- busy_vec  out  2^ADDR_W  current scoreboard, bit i = register i has an outstanding producer

## Operation
- Storage: 2^ADDR_W x DATA_W array, one write port and two read ports, plus a 2^ADDR_W busy vector.
- Write: on an edge with RegWrite=1, the array entry at WriteReg takes Writedata, and busy[WriteReg] clears unless a reservation for the same address wins (see below). With ZERO_REG=1 and WriteReg=0, the edge is a no-op.
- Read/forward: at each edge, op1 and op2 load the current array value of rs1 and rs2.
  - If RegWrite=1 and WriteReg equals the source address on that edge, the operand loads Writedata instead (write-through bypass).
  - With ZERO_REG=1, an address of 0 always loads 0, with no bypass.
- opcode loads the instruction opcode field every edge.
- Hazard: a source is hazardous when busy[addr]=1 and it is not being written this edge (RegWrite=1 and WriteReg=addr clears the hazard). stall loads the OR over rs1 and rs2. Register 0 is never hazardous when ZERO_REG=1.
- Reserve: if Reserve=1 and the hazard condition is false on the same edge, busy[rd] sets. If a hazard exists, no reservation is made; the control unit re-presents the instruction.
- Same-edge write and reserve to the same address: the reserve wins and busy stays 1 (new producer); the array still takes Writedata.
- Reserve of rd=0 with ZERO_REG=1 is ignored.
- busy_vec is the busy register itself, updated at the edge.

## Timing
- Read latency is 1 cycle: instruc_in sampled at edge N gives op1/op2/opcode/stall valid after edge N, held until edge N+1.
- A write at edge N is visible in the array for reads at edge N+1. The same-edge read sees it through the bypass, so there is effectively zero-cycle write-to-read.
- A busy bit set at edge N affects the hazard check from edge N+1. It clears at the write edge, and that edge's read is already non-stalled because of the bypass.
- Reset (synchronous, reset=1 at an edge):
  - all array entries, op1, op2, opcode, stall and busy_vec go to 0;
  - RegWrite and Reserve on that edge are ignored;
  - reset mid-operation discards all reservations.
- No combinational path from any input to any output.

## Test plan
- Reset: hold reset for 1 edge with RegWrite=1, Writedata=FFFF -> after the edge op1=op2=0000, opcode=0, stall=0, busy_vec=0; a following read of that register returns 0000.
- Write then read: write R1=FFFF and R2=1234 on two edges, then instruc_in=F120 -> next cycle opcode=F, op1=FFFF, op2=1234, stall=0.
- Bypass: instruc_in=A340 with RegWrite=1, WriteReg=3, Writedata=BEEF on the same edge -> op1=BEEF; R3 reads BEEF on later cycles.
- Zero register (ZERO_REG=1): write R0=5555, then instruc_in=1000 -> op1=0000, op2=0000. Reserve with rd=0 -> busy_vec stays 0.
- Scoreboard:
  - instruc_in=2125 with Reserve=1 -> busy_vec[5]=1.
  - Next instruc_in=3500 -> stall=1.
  - Edge with RegWrite=1, WriteReg=5, Writedata=0042 and instruc_in=3500 -> stall=0, op1=0042, busy_vec[5]=0.
  - Reserve blocked by a hazard leaves busy_vec unchanged.
- Collision and reset mid-run:
  - Same-edge RegWrite to R7 plus Reserve with rd=7 -> R7 updated, busy_vec[7] stays 1.
  - Assert reset with busy bits set -> busy_vec=0 and stall=0 after one edge.
  - Re-run with DATA_W=32, ADDR_W=5 -> same results on 32-bit data.

Source files
------------

// File: rtl/regfile_fwd.sv
// Register-file read stage: registered operands, write-through bypass
// and a per-register busy scoreboard for RAW hazard stalls.
module regfile_fwd #(
  parameter  int DATA_W   = 16,
  parameter  int ADDR_W   = 4,
  parameter  int OPC_W    = 4,
  parameter  int ZERO_REG = 1,
  localparam int INSTR_W  = OPC_W + 3*ADDR_W,
  localparam int DEPTH    = 1 << ADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] instruc_in,
  input  logic               Reserve,
  input  logic [DATA_W-1:0]  Writedata,
  input  logic [ADDR_W-1:0]  WriteReg,
  input  logic               RegWrite,
  output logic [DATA_W-1:0]  op1,
  output logic [DATA_W-1:0]  op2,
  output logic [OPC_W-1:0]   opcode,
  output logic               stall,
  output logic [DEPTH-1:0]   busy_vec
);

  localparam bit ZR = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] op1_q, op2_q;
  logic [OPC_W-1:0]  opc_q;
  logic              stall_q;

  logic [OPC_W-1:0]  opc;
  logic [ADDR_W-1:0] rs1, rs2, rd;

  assign opc = instruc_in[INSTR_W-1 -: OPC_W];
  assign rs1 = instruc_in[3*ADDR_W-1 -: ADDR_W];
  assign rs2 = instruc_in[2*ADDR_W-1 -: ADDR_W];
  assign rd  = instruc_in[ADDR_W-1:0];

  logic z1, z2, zd, zw;
  assign z1 = ZR && (rs1 == '0);
  assign z2 = ZR && (rs2 == '0);
  assign zd = ZR && (rd == '0);
  assign zw = ZR && (WriteReg == '0);

  logic hit1, hit2, wr_en;
  assign hit1  = RegWrite && (WriteReg == rs1);
  assign hit2  = RegWrite && (WriteReg == rs2);
  assign wr_en = RegWrite && !zw;

  // A write landing this edge resolves the hazard it would have raised.
  logic haz1, haz2, hazard;
  assign haz1   = !z1 && busy_q[rs1] && !hit1;
  assign haz2   = !z2 && busy_q[rs2] && !hit2;
  assign hazard = haz1 || haz2;

  logic [DATA_W-1:0] rd1, rd2;
  assign rd1 = z1 ? '0 : (hit1 ? Writedata : mem_q[rs1]);
  assign rd2 = z2 ? '0 : (hit2 ? Writedata : mem_q[rs2]);

  // Reservation applied after the clear so a new producer wins.
  always_comb begin
    busy_d = busy_q;
    if (wr_en)
      busy_d[WriteReg] = 1'b0;
    if (Reserve && !hazard && !zd)
      busy_d[rd] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        mem_q[i] <= '0;
      busy_q  <= '0;
      op1_q   <= '0;
      op2_q   <= '0;
      opc_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      if (wr_en)
        mem_q[WriteReg] <= Writedata;
      busy_q  <= busy_d;
      op1_q   <= rd1;
      op2_q   <= rd2;
      opc_q   <= opc;
      stall_q <= hazard;
    end
  end

  assign op1      = op1_q;
  assign op2      = op2_q;
  assign opcode   = opc_q;
  assign stall    = stall_q;
  assign busy_vec = busy_q;

endmodule

// File: tb/tb_regfile_fwd.sv
// Bench for regfile_fwd: directed vector table, hand sequences,
// and randomized traffic against a behavioural model.
module tb_regfile_fwd #(
  parameter int DW = 16,
  parameter int AW = 4,
  parameter int OW = 4,
  parameter int ZR = 1
);
  localparam int IW    = OW + 3*AW;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] instruc_in;
  logic          Reserve;
  logic [DW-1:0] Writedata;
  logic [AW-1:0] WriteReg;
  logic          RegWrite;
  logic [DW-1:0] op1, op2;
  logic [OW-1:0] opcode;
  logic          stall;
  logic [DEPTH-1:0] busy_vec;

  always #5 clk = ~clk;

  regfile_fwd #(
    .DATA_W(DW), .ADDR_W(AW), .OPC_W(OW), .ZERO_REG(ZR)
  ) dut (
    .clk(clk), .reset(reset), .instruc_in(instruc_in),
    .Reserve(Reserve), .Writedata(Writedata),
    .WriteReg(WriteReg), .RegWrite(RegWrite),
    .op1(op1), .op2(op2), .opcode(opcode),
    .stall(stall), .busy_vec(busy_vec)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(string nm, logic [63:0] act,
                     logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  // Behavioural model
  logic [DW-1:0] m_mem [DEPTH];
  bit            m_busy [DEPTH];
  logic [DW-1:0] e_op1, e_op2;
  logic [OW-1:0] e_opc;
  bit            e_stall;

  function automatic bit is_z(int a);
    return (ZR != 0) && (a == 0);
  endfunction

  function automatic logic [DEPTH-1:0] m_bvec();
    logic [DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_step();
    int s1, s2, d, w;
    bit h1, h2, wb1, wb2;
    s1 = int'(instruc_in[3*AW-1 -: AW]);
    s2 = int'(instruc_in[2*AW-1 -: AW]);
    d  = int'(instruc_in[AW-1:0]);
    w  = int'(WriteReg);
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_mem[i] = '0;
        m_busy[i] = 0;
      end
      e_op1 = '0; e_op2 = '0; e_opc = '0; e_stall = 0;
      return;
    end
    wb1 = RegWrite && (w == s1);
    wb2 = RegWrite && (w == s2);
    e_op1 = is_z(s1) ? '0 : (wb1 ? Writedata : m_mem[s1]);
    e_op2 = is_z(s2) ? '0 : (wb2 ? Writedata : m_mem[s2]);
    e_opc = instruc_in[IW-1 -: OW];
    h1 = !is_z(s1) && m_busy[s1] && !wb1;
    h2 = !is_z(s2) && m_busy[s2] && !wb2;
    e_stall = h1 || h2;
    if (RegWrite && !is_z(w)) begin
      m_mem[w] = Writedata;
      m_busy[w] = 0;
    end
    if (Reserve && !e_stall && !is_z(d))
      m_busy[d] = 1;
  endtask

  function automatic logic [IW-1:0] mk(logic [31:0] o,
    logic [31:0] a, logic [31:0] b, logic [31:0] c);
    return {o[OW-1:0], a[AW-1:0], b[AW-1:0], c[AW-1:0]};
  endfunction

  task automatic apply(bit r, logic [IW-1:0] ins, bit res,
    bit we, logic [31:0] wa, logic [31:0] wd);
    @(negedge clk);
    reset = r; instruc_in = ins; Reserve = res;
    RegWrite = we; WriteReg = wa[AW-1:0];
    Writedata = wd[DW-1:0];
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_model(string tag);
    chk({tag, ".op1"}, 64'(op1), 64'(e_op1));
    chk({tag, ".op2"}, 64'(op2), 64'(e_op2));
    chk({tag, ".opc"}, 64'(opcode), 64'(e_opc));
    chk({tag, ".stall"}, 64'(stall), 64'(e_stall));
    chk({tag, ".busy"}, 64'(busy_vec), 64'(m_bvec()));
  endtask

  typedef struct {
    bit r; logic [31:0] o, a, b, c;
    bit res, we; logic [31:0] wa, wd;
    logic [31:0] e1, e2, eo; bit es; logic [31:0] eb;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  initial begin
    reset = 1'b1; instruc_in = '0; Reserve = 1'b0;
    Writedata = '0; WriteReg = '0; RegWrite = 1'b0;

    //          r  o  a  b  c  res we wa  wd       e1       e2       eo es eb
    tbl[0]  = '{1, 0, 1, 1, 0, 0, 1, 1, 'hFFFF, 0,       0,       0, 0, 0};
    tbl[1]  = '{0, 0, 1, 1, 0, 0, 0, 0, 0,      0,       0,       0, 0, 0};
    tbl[2]  = '{0, 0, 0, 0, 0, 0, 1, 1, 'hFFFF, 0,       0,       0, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 0, 0, 1, 2, 'h1234, 0,       0,       0, 0, 0};
    tbl[4]  = '{0,15, 1, 2, 0, 0, 0, 0, 0,      'hFFFF,  'h1234,  15,0, 0};
    tbl[5]  = '{0,10, 3, 4, 0, 0, 1, 3, 'hBEEF, 'hBEEF,  0,       10,0, 0};
    tbl[6]  = '{0,10, 3, 4, 0, 0, 0, 0, 0,      'hBEEF,  0,       10,0, 0};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 1, 0, 'h5555, 0,       0,       1, 0, 0};
    tbl[8]  = '{0, 1, 0, 0, 0, 0, 0, 0, 0,      0,       0,       1, 0, 0};
    tbl[9]  = '{0, 2, 0, 0, 0, 1, 0, 0, 0,      0,       0,       2, 0, 0};
    tbl[10] = '{0, 2, 1, 2, 5, 1, 0, 0, 0,      'hFFFF,  'h1234,  2, 0, 'h20};
    tbl[11] = '{0, 3, 5, 0, 0, 0, 0, 0, 0,      0,       0,       3, 1, 'h20};
    tbl[12] = '{0, 3, 5, 0, 0, 0, 1, 5, 'h0042, 'h0042,  0,       3, 0, 0};
    tbl[13] = '{0, 4, 1, 0, 6, 1, 0, 0, 0,      'hFFFF,  0,       4, 0, 'h40};
    tbl[14] = '{0, 4, 6, 0, 8, 1, 0, 0, 0,      0,       0,       4, 1, 'h40};
    tbl[15] = '{0, 5, 1, 2, 7, 1, 1, 7, 'h7777, 'hFFFF,  'h1234,  5, 0, 'hC0};
    tbl[16] = '{0, 6, 7, 0, 0, 0, 0, 0, 0,      'h7777,  0,       6, 1, 'hC0};
    tbl[17] = '{1, 6, 7, 0, 0, 1, 1, 7, 'h1111, 0,       0,       0, 0, 0};
    tbl[18] = '{0, 6, 7, 2, 0, 0, 0, 0, 0,      0,       0,       6, 0, 0};

    repeat (2) @(posedge clk);

    for (int i = 0; i < NV; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      apply(tbl[i].r, mk(tbl[i].o, tbl[i].a, tbl[i].b, tbl[i].c),
            tbl[i].res, tbl[i].we, tbl[i].wa, tbl[i].wd);
      chk({t, ".op1"}, 64'(op1), 64'(tbl[i].e1[DW-1:0]));
      chk({t, ".op2"}, 64'(op2), 64'(tbl[i].e2[DW-1:0]));
      chk({t, ".opc"}, 64'(opcode), 64'(tbl[i].eo[OW-1:0]));
      chk({t, ".stall"}, 64'(stall), 64'(tbl[i].es));
      chk({t, ".busy"}, 64'(busy_vec),
          64'(tbl[i].eb[DEPTH-1:0]));
    end

    // Collision write+reserve on R9, then a multi-cycle stall.
    apply(0, mk(7, 0, 0, 9), 1, 1, 9, 'hA5A5);
    chk("coll.busy9", 64'(busy_vec[9]), 64'd1);
    chk_model("coll");
    for (int k = 0; k < 3; k++) begin
      apply(0, mk(7, 9, 9, 0), 0, 0, 0, 0);
      chk("hold.stall", 64'(stall), 64'd1);
      chk("hold.op1", 64'(op1), 64'(DW'('hA5A5)));
    end
    apply(0, mk(7, 9, 9, 0), 0, 1, 9, 'h0BAD);
    chk("rel.stall", 64'(stall), 64'd0);
    chk("rel.op2", 64'(op2), 64'(DW'('h0BAD)));
    chk("rel.busy9", 64'(busy_vec[9]), 64'd0);
    chk_model("rel");

    // Randomized traffic; small address range raises hit rate.
    for (int n = 0; n < 400; n++) begin
      logic [31:0] o, a, b, c, wa, wd;
      bit r, res, we;
      r   = ($urandom_range(63) == 0);
      o   = $urandom;
      a   = $urandom_range(DEPTH - 1);
      b   = $urandom_range(7);
      c   = $urandom_range(7);
      res = ($urandom_range(2) == 0);
      we  = ($urandom_range(1) == 0);
      wa  = $urandom_range(7);
      wd  = $urandom;
      apply(r, mk(o, a, b, c), res, we, wa, wd);
      chk_model($sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
